// File: rtl/beat_player_pkg.sv
// Shared definitions for the beat player: FSM state encoding, the tone-table
// value that marks a silent beat, and the beat index width.
package beat_player_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Tone-table entry used for rests; anything >= SIL_MIN is silent anyway.
    localparam logic [31:0] SIL    = 32'd50_000_000;
    localparam int          BEAT_W = 12;

endpackage

// File: rtl/beat_player_tone_gen.sv
// Square-wave generator for one audio channel.
// A phase accumulator adds the tone frequency every clock. Each time the sum
// reaches CLK_HZ/2, half a period has elapsed: subtract CLK_HZ/2 and toggle.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   en_i        1 = accumulate, 0 = hold accumulator and output at 0
//   tone_i      tone frequency in Hz (0 or >= SIL_MIN means silence)
//   audio_o     speaker drive
module tone_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SIL_MIN = 20_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [31:0] tone_i,
    output logic        audio_o
);

    localparam logic [32:0] HALF = 33'(CLK_HZ / 2);

    logic [32:0] acc_q, acc_d, sum;
    logic        aud_q, aud_d;
    logic        silent;

    assign silent = (tone_i == 32'd0) || (tone_i >= 32'(SIL_MIN));

    always_comb begin
        acc_d = acc_q;
        aud_d = aud_q;
        sum   = acc_q + {1'b0, tone_i};
        if (!en_i || silent) begin
            acc_d = '0;
            aud_d = 1'b0;
        end else if (sum >= HALF) begin
            acc_d = sum - HALF;
            aud_d = ~aud_q;
        end else begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            aud_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            aud_q <= aud_d;
        end
    end

    assign audio_o = aud_q;

endmodule

// File: rtl/beat_player.sv
// Song sequencer: steps a beat index through a tone table at BEAT_HZ and
// drives two square-wave speaker channels from the returned tones.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   start, stop       one-cycle play / abort requests (stop wins)
//   loop_en           wrap to beat 0 after last_beat instead of finishing
//   last_beat         index of the final beat
//   ibeatNum          current beat index to the tone table
//   toneL, toneR      tone table outputs (Hz)
//   audio_l, audio_r  speaker drive
//   playing           high in PLAY
//   done              one-cycle pulse on non-loop completion
module beat_player
    import beat_player_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BEAT_HZ = 8,
    parameter int SIL_MIN = 20_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [BEAT_W-1:0] last_beat,
    output logic [BEAT_W-1:0] ibeatNum,
    input  logic [31:0]       toneL,
    input  logic [31:0]       toneR,
    output logic              audio_l,
    output logic              audio_r,
    output logic              playing,
    output logic              done
);

    localparam int BEAT_CYC = CLK_HZ / BEAT_HZ;
    localparam int CNT_W    = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEAT_CYC - 1);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              tick;

    assign tick = (state_q == PLAY) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                cnt_d  = '0;
                if (start && !stop) state_d = PLAY;
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = '0;
                    if (beat_q != last_beat) begin
                        beat_d = BEAT_W'(beat_q + 1'b1);
                    end else if (loop_en) begin
                        beat_d = '0;
                    end else begin
                        state_d = IDLE;
                        beat_d  = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Channels follow the next state so audio is already low in the first
    // IDLE cycle after a stop or completion.
    logic tone_en;
    assign tone_en = (state_d == PLAY);

    tone_gen #(.CLK_HZ(CLK_HZ), .SIL_MIN(SIL_MIN)) u_tone_l (
        .clk(clk), .rst_n(rst_n), .en_i(tone_en), .tone_i(toneL), .audio_o(audio_l)
    );

    tone_gen #(.CLK_HZ(CLK_HZ), .SIL_MIN(SIL_MIN)) u_tone_r (
        .clk(clk), .rst_n(rst_n), .en_i(tone_en), .tone_i(toneR), .audio_o(audio_r)
    );

    assign ibeatNum = beat_q;
    assign playing  = (state_q == PLAY);
    assign done     = done_q;

endmodule
